// File: rtl/ram_bist_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ram_bist_pkg
//  Purpose  : Shared state encoding and default pattern seed for the RAM BIST.
//  Revision : 1.0  initial release
// ============================================================================
package ram_bist_pkg;

    localparam int unsigned c_default_seed = 32'h0000_00A5;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR0  = 3'd1,
        S_RD0  = 3'd2,
        S_WR1  = 3'd3,
        S_RD1  = 3'd4,
        S_DONE = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ram_bist_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : ram_bist_ctrl_if
//  Purpose  : Single-port RAM bus (sync write, async read) driven by the BIST.
//  Revision : 1.0  initial release
// ============================================================================
interface ram_bist_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) ();

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport master (output mem_we, output mem_addr, output mem_din, input  mem_dout);
    modport slave  (input  mem_we, input  mem_addr, input  mem_din, output mem_dout);

endinterface
`default_nettype wire

// File: rtl/ram_bist_pattern.sv
`default_nettype none
// ============================================================================
//  Module   : ram_bist_pattern
//  Purpose  : Expected data for an address: SEED ^ addr, inverted in phase 1.
//  Revision : 1.0  initial release
// ============================================================================
module ram_bist_pattern
    import ram_bist_pkg::*;
#(
    parameter int          ADDR_W = 4,
    parameter int          DATA_W = 8,
    parameter int unsigned SEED   = c_default_seed
) (
    input  wire logic [ADDR_W-1:0] addr,
    input  wire logic              phase,
    output logic      [DATA_W-1:0] expected
);

    localparam logic [DATA_W-1:0] c_seed = DATA_W'(SEED);

    logic [DATA_W-1:0] w_base;

    // Width cast zero-extends a narrow address or keeps only its low DATA_W bits.
    assign w_base   = c_seed ^ DATA_W'(addr);
    assign expected = phase ? ~w_base : w_base;

endmodule
`default_nettype wire

// File: rtl/ram_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ram_bist_ctrl
//  Purpose  : March-style RAM self test: write/read pattern, then its inverse.
//  Revision : 1.0  initial release
// ============================================================================
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int          ADDR_W = 4,
    parameter int          DATA_W = 8,
    parameter int unsigned SEED   = c_default_seed
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              start,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic      [ADDR_W-1:0] fail_addr,
    output logic      [DATA_W-1:0] fail_data,
    output logic                   fail_phase,
    ram_bist_ctrl_if.master        bus
);

    localparam int                DEPTH      = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_cnt_last = ADDR_W'(DEPTH - 1);

    state_t            r_state,      w_state_nxt;
    logic [ADDR_W-1:0] r_cnt,        w_cnt_nxt;
    logic              r_pass,       w_pass_nxt;
    logic [ADDR_W-1:0] r_fail_addr,  w_fail_addr_nxt;
    logic [DATA_W-1:0] r_fail_data,  w_fail_data_nxt;
    logic              r_fail_phase, w_fail_phase_nxt;

    logic              w_phase;
    logic [DATA_W-1:0] w_expected;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_din;

    assign w_phase = (r_state == S_WR1) || (r_state == S_RD1);

    ram_bist_pattern #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .SEED   (SEED)
    ) u_pattern (
        .addr     (r_cnt),
        .phase    (w_phase),
        .expected (w_expected)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_pass       <= 1'b0;
            r_fail_addr  <= '0;
            r_fail_data  <= '0;
            r_fail_phase <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_pass       <= w_pass_nxt;
            r_fail_addr  <= w_fail_addr_nxt;
            r_fail_data  <= w_fail_data_nxt;
            r_fail_phase <= w_fail_phase_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_pass_nxt       = r_pass;
        w_fail_addr_nxt  = r_fail_addr;
        w_fail_data_nxt  = r_fail_data;
        w_fail_phase_nxt = r_fail_phase;
        w_we             = 1'b0;
        w_addr           = '0;
        w_din            = '0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt      = S_WR0;
                    w_cnt_nxt        = '0;
                    w_pass_nxt       = 1'b0;
                    w_fail_addr_nxt  = '0;
                    w_fail_data_nxt  = '0;
                    w_fail_phase_nxt = 1'b0;
                end
            end
            S_WR0, S_WR1: begin
                w_we   = 1'b1;
                w_addr = r_cnt;
                w_din  = w_expected;
                if (r_cnt == c_cnt_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (r_state == S_WR0) ? S_RD0 : S_RD1;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            S_RD0, S_RD1: begin
                w_addr = r_cnt;
                // Read data is combinational, so compare within the same cycle.
                if (bus.mem_dout != w_expected) begin
                    w_fail_addr_nxt  = r_cnt;
                    w_fail_data_nxt  = bus.mem_dout;
                    w_fail_phase_nxt = w_phase;
                    w_pass_nxt       = 1'b0;
                    w_state_nxt      = S_DONE;
                end else if (r_cnt == c_cnt_last) begin
                    w_cnt_nxt = '0;
                    if (r_state == S_RD0) begin
                        w_state_nxt = S_WR1;
                    end else begin
                        w_state_nxt = S_DONE;
                        w_pass_nxt  = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign busy       = (r_state == S_WR0) || (r_state == S_RD0) ||
                        (r_state == S_WR1) || (r_state == S_RD1);
    assign done       = (r_state == S_DONE);
    assign pass       = r_pass;
    assign fail_addr  = r_fail_addr;
    assign fail_data  = r_fail_data;
    assign fail_phase = r_fail_phase;

    assign bus.mem_we   = w_we;
    assign bus.mem_addr = w_addr;
    assign bus.mem_din  = w_din;

endmodule
`default_nettype wire

// File: doc/ram_bist_ctrl.md
Name: ram_bist_ctrl

Overview:
- Initiator-side controller for the single-port RAM with synchronous write and asynchronous read (ports clk, we, addr, din, dout).
- On `start`, it writes a deterministic pattern to every address and reads it back. It then writes and reads back the inverted pattern.
- It reports pass/fail, plus the first failing address, data and phase.
- Sits between system control and one RAM instance. It owns the RAM's we/addr/din during a test.

Parameters:
- ADDR_W, 4, RAM address width; DEPTH = 2**ADDR_W.
- DATA_W, 8, RAM data width.
- SEED, 8'hA5, base pattern; truncated or zero-extended to DATA_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request test; sampled only in IDLE or DONE.
- busy  output  1  high while in WR0/RD0/WR1/RD1.
- done  output  1  high while in DONE.
- pass  output  1  valid when done=1; 1 = no mismatch.
- fail_addr  output  ADDR_W  address of first mismatch.
- fail_data  output  DATA_W  value read at first mismatch.
- fail_phase  output  1  0 = mismatch found in RD0, 1 = mismatch found in RD1.
- mem_we  output  1  to RAM we.
- mem_addr  output  ADDR_W  to RAM addr.
- mem_din  output  DATA_W  to RAM din.
- mem_dout  input  DATA_W  from RAM dout; combinational read of mem_addr.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, address counter=0.
  - busy, done, pass, mem_we = 0.
  - mem_addr, mem_din, fail_addr, fail_data, fail_phase = 0.
- Reset mid-test aborts immediately to IDLE. RAM contents are left as they were.
- Pattern: base(a) = SEED ^ zero-extend(a) to DATA_W (if DATA_W < ADDR_W, use the low DATA_W bits of a).
  - Phase 0 expects base(a).
  - Phase 1 expects ~base(a).
- States and transitions:
  - IDLE: start=1 -> WR0, counter=0, fail_* cleared.
  - WR0: mem_we=1, mem_addr=counter, mem_din=base(counter). One address per cycle, counter+1. At counter=DEPTH-1 -> RD0, counter=0.
  - RD0: mem_we=0, mem_addr=counter. mem_dout is compared to base(counter) in the same cycle.
    - Match: counter+1; at DEPTH-1 -> WR1, counter=0.
    - Mismatch: capture fail_addr=counter, fail_data=mem_dout, fail_phase=0, pass=0 -> DONE (abort).
  - WR1: as WR0 with mem_din=~base(counter); at DEPTH-1 -> RD1.
  - RD1: as RD0 with expected ~base, fail_phase=1. At DEPTH-1 with no mismatch -> DONE, pass=1.
  - DONE: done=1; pass and fail_* hold. start=1 -> WR0 (clears pass and fail_*, counter=0). Otherwise stay.
- busy and done decode directly from the state register; no extra latency.
- Timing: start sampled at edge E0. busy is high for 4*DEPTH cycles (64 at defaults); done rises after edge E0+4*DEPTH.
- start while busy is ignored.
- mem_we is never high outside WR0/WR1.
- Outside WR states: mem_din=0. Outside WR/RD states: mem_addr=0.
- Counter wraps only via the explicit DEPTH-1 transition; no natural overflow is relied on.

Decomposition:
- Shared package/include ram_bist_pkg:
  - state encoding localparams: S_IDLE, S_WR0, S_RD0, S_WR1, S_RD1, S_DONE.
  - default SEED.
- One combinational sub-module, ram_bist_pattern: inputs addr and phase, output expected data. Used for both write data and compare.

Test Plan:
- Clean RAM, defaults: pulse start for one cycle -> busy high exactly 64 cycles; done=1, pass=1, fail_* = 0. Writes observed: addr0=A5, addr3=A6, addrF=AA in WR0; addr0=5A in WR1.
- Stuck-at-1 on bit0 of addr 3 in the bench RAM model -> RD0 reads A7 instead of A6. done after 16+4=20 busy cycles; pass=0, fail_addr=3, fail_data=A7, fail_phase=0.
- Fault only on inverted data (bit7 of addr 5 stuck at 0) -> phase 0 passes. RD1 expects 5F and reads 5F&7F=5F... choose bit4 instead: expected 5F, read 4F. Result: fail_addr=5, fail_data=4F, fail_phase=1, pass=0.
- rst_n pulled low during RD0 at counter 7 -> all outputs 0 immediately (asynchronous). State is IDLE after release. A new start then runs a full 64-cycle test with pass=1.
- start held high continuously from IDLE -> re-launch is only taken in DONE. busy drops for exactly one cycle (done=1) between runs. start pulses during busy have no effect on counters.
- start asserted in DONE after a failing run -> fail_* and pass cleared in the first WR0 cycle. Healthy RAM then yields pass=1.
